// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - pad synchroniser, per-pin debounce, edge detect and edge-pending irq
// Optional feature macro: GPIO_COND_IRQ_EN enables pend_o/irq_o; otherwise both are tied low.
module gpio_input_conditioner #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE    = 1000,
   parameter int DB_COUNT    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] pins_i,
   input  logic [WIDTH-1:0] db_en_i,
   input  logic [WIDTH-1:0] irq_en_i,
   input  logic [WIDTH-1:0] pend_clr_i,
   output logic [WIDTH-1:0] clean_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic [WIDTH-1:0] pend_o,
   output logic             irq_o
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(DB_COUNT + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DB_COUNT - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [PW-1:0]    presc_q;
   logic             tick;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pins_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // Single prescaler shared by all pins; tick marks the last count before wrap.
   assign tick = (presc_q == PRESC_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) presc_q <= '0;
      else         presc_q <= tick ? '0 : presc_q + 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      logic [CW-1:0] cnt_q, cnt_d;
      logic          clean_q, clean_d, rise_q, fall_q;

      // A mismatch only advances on ticks; any cycle of agreement restarts the count.
      always_comb begin
         clean_d = clean_q;
         cnt_d   = cnt_q;
         if (!db_en_i[i]) begin
            clean_d = sync[i];
            cnt_d   = '0;
         end else if (sync[i] == clean_q) begin
            cnt_d = '0;
         end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
               clean_d = sync[i];
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
            fall_q  <= ~clean_d & clean_q;
         end
      end

      assign clean_o[i] = clean_q;
      assign rise_o[i]  = rise_q;
      assign fall_o[i]  = fall_q;
   end

`ifdef GPIO_COND_IRQ_EN
   logic [WIDTH-1:0] pend_q;

   // Set has priority over clear so an edge coinciding with a clear is not lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pend_q <= '0;
      else         pend_q <= (pend_q & ~pend_clr_i) | ((rise_o | fall_o) & irq_en_i);
   end

   assign pend_o = pend_q;
   assign irq_o  = |pend_q;
`else
   logic unused_irq_inputs;
   assign unused_irq_inputs = ^{irq_en_i, pend_clr_i};
   assign pend_o = '0;
   assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - scoreboard bench for gpio_input_conditioner
module tb_gpio_input_conditioner;
   localparam int W = 16;
`ifdef GPIO_COND_IRQ_EN
   localparam logic IRQ_BUILD = 1'b1;
`else
   localparam logic IRQ_BUILD = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } pulse_t;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [W-1:0] pins_i, db_en_i, irq_en_i, pend_clr_i;
   logic [W-1:0] clean_o, rise_o, fall_o, pend_o;
   logic         irq_o;

   pulse_t exp_q[$];
   pulse_t obs_q[$];
   int     checks = 0;
   int     errors = 0;
   logic   mon_en = 1'b0;

   gpio_input_conditioner #(
      .WIDTH(W), .SYNC_STAGES(2), .PRESCALE(4), .DB_COUNT(3)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pins_i(pins_i), .db_en_i(db_en_i),
      .irq_en_i(irq_en_i), .pend_clr_i(pend_clr_i), .clean_o(clean_o),
      .rise_o(rise_o), .fall_o(fall_o), .pend_o(pend_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i)
      if (mon_en && ((rise_o | fall_o) != '0)) obs_q.push_back({rise_o, fall_o});

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic test_reset;
      pulse_t e, o;
      rst_ni = 1'b0; pins_i = 16'hFFFF; db_en_i = '0; irq_en_i = '0; pend_clr_i = '0;
      step(3);
      checks++; if (clean_o !== 16'h0) begin errors++; $display("FAIL reset_clean got %h want 0000", clean_o); end
      checks++; if ((rise_o | fall_o) !== 16'h0) begin errors++; $display("FAIL reset_edges got %h want 0000", rise_o | fall_o); end
      checks++; if (pend_o !== 16'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL reset_pend got %h/%b want 0000/0", pend_o, irq_o); end
      rst_ni = 1'b1; mon_en = 1'b1;
      exp_q.push_back({16'hFFFF, 16'h0000});
      step(2);
      checks++; if (clean_o !== 16'h0) begin errors++; $display("FAIL reset_early_clean got %h want 0000", clean_o); end
      step(1);
      checks++; if (clean_o !== 16'hFFFF || rise_o !== 16'hFFFF) begin errors++; $display("FAIL reset_release got clean=%h rise=%h want FFFF FFFF", clean_o, rise_o); end
      step(1);
      checks++; if (rise_o !== 16'h0) begin errors++; $display("FAIL reset_rise_width got %h want 0000", rise_o); end
      step(1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL reset_pulse got none want rise=%h fall=%h", e.rise, e.fall); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL reset_pulse got rise=%h fall=%h want rise=%h fall=%h", o.rise, o.fall, e.rise, e.fall); end
         end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_extra got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_debounce;
      pulse_t e, o;
      int lat;
      logic found;
      exp_q.push_back({16'h0000, 16'hFFFF});
      pins_i = 16'h0000;
      step(5);
      db_en_i = 16'hFFFF;
      step(1);
      exp_q.push_back({16'h0001, 16'h0000});
      pins_i = 16'h0001;
      found = 1'b0; lat = 0;
      for (int i = 1; i <= 40 && !found; i++) begin
         step(1);
         if (clean_o[0]) begin found = 1'b1; lat = i; end
      end
      checks++; if (!found || lat < 11 || lat > 14) begin errors++; $display("FAIL debounce_latency got %0d (found=%b) want 11..14", lat, found); end
      checks++; if (clean_o !== 16'h0001) begin errors++; $display("FAIL debounce_clean got %h want 0001", clean_o); end
      step(3);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL debounce_pulse got none want rise=%h fall=%h", e.rise, e.fall); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL debounce_pulse got rise=%h fall=%h want rise=%h fall=%h", o.rise, o.fall, e.rise, e.fall); end
         end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL debounce_extra got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_glitch;
      pulse_t e, o;
      logic leaked = 1'b0;
      pins_i = 16'h0009;
      for (int i = 0; i < 6; i++) begin step(1); leaked |= clean_o[3]; end
      pins_i = 16'h0001;
      for (int i = 0; i < 20; i++) begin step(1); leaked |= clean_o[3]; end
      checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL glitch_reject got clean3=1 want 0"); end
      db_en_i = 16'hFFF7;
      exp_q.push_back({16'h0008, 16'h0000});
      exp_q.push_back({16'h0000, 16'h0008});
      pins_i = 16'h0009;
      step(6);
      pins_i = 16'h0001;
      step(6);
      db_en_i = 16'hFFFF;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL glitch_pulse got none want rise=%h fall=%h", e.rise, e.fall); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL glitch_pulse got rise=%h fall=%h want rise=%h fall=%h", o.rise, o.fall, e.rise, e.fall); end
         end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_extra got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_pending;
      pulse_t e, o;
      logic [W-1:0] exp_pend;
      exp_pend = IRQ_BUILD ? 16'h0001 : 16'h0000;
      db_en_i = 16'h0000; irq_en_i = 16'h0001;
      step(1);
      exp_q.push_back({16'h0002, 16'h0001});
      pins_i = 16'h0002;
      step(5);
      checks++; if (pend_o !== exp_pend || irq_o !== IRQ_BUILD) begin errors++; $display("FAIL pend_set got %h/%b want %h/%b", pend_o, irq_o, exp_pend, IRQ_BUILD); end
      exp_q.push_back({16'h0001, 16'h0000});
      pins_i = 16'h0003;
      step(3);
      checks++; if (rise_o !== 16'h0001) begin errors++; $display("FAIL pend_rise_align got %h want 0001", rise_o); end
      pend_clr_i = 16'h0001;
      step(1);
      pend_clr_i = 16'h0000;
      checks++; if (pend_o !== exp_pend) begin errors++; $display("FAIL pend_set_wins got %h want %h", pend_o, exp_pend); end
      irq_en_i = 16'h0000;
      step(2);
      checks++; if (pend_o !== exp_pend || irq_o !== IRQ_BUILD) begin errors++; $display("FAIL pend_hold got %h/%b want %h/%b", pend_o, irq_o, exp_pend, IRQ_BUILD); end
      pend_clr_i = 16'h0001;
      step(1);
      pend_clr_i = 16'h0000;
      checks++; if (pend_o !== 16'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL pend_clear got %h/%b want 0000/0", pend_o, irq_o); end
      step(1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL pend_pulse got none want rise=%h fall=%h", e.rise, e.fall); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL pend_pulse got rise=%h fall=%h want rise=%h fall=%h", o.rise, o.fall, e.rise, e.fall); end
         end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pend_extra got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_midcount_reset;
      pulse_t e, o;
      db_en_i = 16'hFFFF; irq_en_i = 16'h0000;
      pins_i = 16'h0021;
      step(8);
      rst_ni = 1'b0; mon_en = 1'b0;
      step(2);
      checks++; if (clean_o !== 16'h0 || (rise_o | fall_o) !== 16'h0) begin errors++; $display("FAIL midreset_outputs got clean=%h edges=%h want 0000 0000", clean_o, rise_o | fall_o); end
      checks++; if (pend_o !== 16'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL midreset_pend got %h/%b want 0000/0", pend_o, irq_o); end
      exp_q.push_back({16'h0021, 16'h0000});
      rst_ni = 1'b1; mon_en = 1'b1;
      step(11);
      checks++; if (clean_o[5] !== 1'b0) begin errors++; $display("FAIL midreset_early got clean5=%b want 0", clean_o[5]); end
      step(1);
      checks++; if (clean_o !== 16'h0021) begin errors++; $display("FAIL midreset_accept got %h want 0021", clean_o); end
      step(2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL midreset_pulse got none want rise=%h fall=%h", e.rise, e.fall); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL midreset_pulse got rise=%h fall=%h want rise=%h fall=%h", o.rise, o.fall, e.rise, e.fall); end
         end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_extra got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_pending();
      test_midcount_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
